// File: rtl/matrix_mem_sequencer.sv
// Row sequencer for ld.m / st.m: splits one matrix transfer into DIM strided row
// transactions between the data memory port and the matrix register file.
module matrix_mem_sequencer #(
  parameter int DIM    = 4,
  parameter int WORD_W = 32,
  localparam int RW    = (DIM > 1) ? $clog2(DIM) : 1,
  localparam int DW    = DIM * WORD_W
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          start,
  input  logic          is_store,
  input  logic [3:0]    matrix_rd,
  input  logic [31:0]   base_addr,
  input  logic [3:0]    stride,
  output logic          busy,
  output logic          done,
  output logic          mem_req,
  output logic          mem_wen,
  output logic [31:0]   mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          mrf_wen,
  output logic          mrf_ren,
  output logic [3:0]    mrf_idx,
  output logic [RW-1:0] mrf_row,
  output logic [DW-1:0] mrf_wdata,
  input  logic [DW-1:0] mrf_rdata
);

  // state  | meaning
  // IDLE   | waiting for start
  // LD_REQ | memory row read pending, row written to register file on mem_ready
  // ST_RD  | register file row read issued
  // ST_REQ | memory row write pending
  // DONE   | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, LD_REQ, ST_RD, ST_REQ, DONE} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic            store_q, store_d;
  logic [3:0]      idx_q, idx_d;
  logic [31:0]     base_q, base_d;
  logic [31:0]     pitch_q, pitch_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            first_q, first_d;
  logic            last_row;

  assign last_row  = (row_q == RW'(DIM - 1));
  assign mem_addr  = base_q + (32'(row_q) * pitch_q);
  assign mrf_idx   = idx_q;
  assign mrf_row   = row_q;
  assign mrf_wdata = mem_rdata;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      row_q   <= '0;
      store_q <= 1'b0;
      idx_q   <= '0;
      base_q  <= '0;
      pitch_q <= '0;
      wdata_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      store_q <= store_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      pitch_q <= pitch_d;
      wdata_q <= wdata_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    store_d   = store_q;
    idx_d     = idx_q;
    base_d    = base_q;
    pitch_d   = pitch_q;
    wdata_d   = wdata_q;
    first_d   = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_wen   = 1'b0;
    mrf_wen   = 1'b0;
    mrf_ren   = 1'b0;
    mem_wdata = wdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          store_d = is_store;
          idx_d   = matrix_rd;
          base_d  = base_addr;
          pitch_d = (stride == 4'd0) ? 32'(4 * DIM) : {26'd0, stride, 2'b00};
          row_d   = '0;
          state_d = is_store ? ST_RD : LD_REQ;
        end
      end
      LD_REQ: begin
        mem_req = 1'b1;
        mrf_wen = mem_ready;
        if (mem_ready) begin
          if (last_row) state_d = DONE;
          else          row_d   = row_q + RW'(1);
        end
      end
      ST_RD: begin
        mrf_ren = 1'b1;
        first_d = 1'b1;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        mem_req = 1'b1;
        mem_wen = 1'b1;
        // Register file data arrives in the first ST_REQ cycle; pass it through
        // and capture it so the row stays stable for the rest of the request.
        if (first_q) begin
          mem_wdata = mrf_rdata;
          wdata_d   = mrf_rdata;
        end
        if (mem_ready) begin
          if (last_row) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + RW'(1);
            state_d = ST_RD;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_matrix_mem_sequencer.sv
// Bench for matrix_mem_sequencer: table vectors, random transfers checked against a
// row-level transfer model, and a mid-transfer reset sequence.
module tb_matrix_mem_sequencer;

  localparam int DIM = 4;
  localparam int DW  = 128;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          start, is_store;
  logic [3:0]    matrix_rd;
  logic [31:0]   base_addr;
  logic [3:0]    stride;
  logic          busy, done, mem_req, mem_wen;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          mrf_wen, mrf_ren;
  logic [3:0]    mrf_idx;
  logic [1:0]    mrf_row;
  logic [DW-1:0] mrf_wdata;
  logic [DW-1:0] mrf_rdata;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] rf [16][DIM];
  logic [31:0]   acc_addr [DIM];

  typedef struct {
    bit          st;
    logic [3:0]  rd;
    logic [31:0] base;
    logic [3:0]  stride;
    int          stall_row;
    int          stall_len;
    bit          rnd;
    bit          noise;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [6];

  matrix_mem_sequencer #(.DIM(DIM), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .is_store(is_store), .matrix_rd(matrix_rd),
    .base_addr(base_addr), .stride(stride), .busy(busy), .done(done), .mem_req(mem_req),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mrf_wen(mrf_wen), .mrf_ren(mrf_ren), .mrf_idx(mrf_idx),
    .mrf_row(mrf_row), .mrf_wdata(mrf_wdata), .mrf_rdata(mrf_rdata)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] pat(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a, a + 32'd1, {a[15:0], a[31:16]}};
  endfunction

  assign mem_rdata = pat(mem_addr);

  // Synchronous-read register file; garbage when not read so held data is exercised.
  always @(posedge CLK) begin
    if (mrf_ren) mrf_rdata <= rf[mrf_idx][mrf_row];
    else         mrf_rdata <= {$urandom(), $urandom(), $urandom(), $urandom()};
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Phase per cycle: 0 = register file read, 1 = memory request, 2 = completion.
  task automatic run_txn(input vec_t v, output int cyc);
    logic [31:0] pitch, ea;
    int row, stall_left, stalls, ph;
    bit rdy, seen_done;
    pitch = (v.stride == 4'd0) ? 32'(4 * DIM) : 32'(4 * v.stride);
    @(negedge CLK);
    start = 1'b1; is_store = v.st; matrix_rd = v.rd; base_addr = v.base; stride = v.stride;
    mem_ready = 1'b0;
    #1 chk("idle_busy", {127'd0, busy}, 128'd0);
    row = 0; stalls = 0; stall_left = v.stall_len; ph = v.st ? 0 : 1; cyc = 0; seen_done = 0;
    while (!seen_done && cyc < 100) begin
      @(negedge CLK);
      if (v.noise) begin
        start     = (ph == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        is_store  = 1'($urandom_range(0, 1));
        matrix_rd = 4'($urandom());
        base_addr = $urandom();
        stride    = 4'($urandom());
      end else begin
        start = 1'b0;
      end
      if (ph == 1) begin
        if (row == v.stall_row && stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
        end else if (v.rnd) begin
          rdy = 1'($urandom_range(0, 1));
        end else begin
          rdy = 1'b1;
        end
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      mem_ready = rdy;
      #1;
      ea = v.base + 32'(row) * pitch;
      chk("busy", {127'd0, busy}, 128'd1);
      chk("mem_req", {127'd0, mem_req}, {127'd0, ph == 1});
      chk("mrf_ren", {127'd0, mrf_ren}, {127'd0, ph == 0});
      chk("done", {127'd0, done}, {127'd0, ph == 2});
      if (ph == 1) begin
        chk("mem_wen", {127'd0, mem_wen}, {127'd0, v.st});
        chk("mem_addr", {96'd0, mem_addr}, {96'd0, ea});
        chk("mrf_idx", {124'd0, mrf_idx}, {124'd0, v.rd});
        chk("mrf_wen", {127'd0, mrf_wen}, {127'd0, !v.st && rdy});
        if (v.st) chk("mem_wdata", mem_wdata, rf[v.rd][row]);
        if (!v.st) chk("ld_row", {126'd0, mrf_row}, 128'(row));
        if (!v.st && rdy) chk("mrf_wdata", mrf_wdata, pat(ea));
        if (rdy) acc_addr[row] = mem_addr;
        else     stalls++;
      end
      if (ph == 0) begin
        chk("st_row", {126'd0, mrf_row}, 128'(row));
        chk("st_idx", {124'd0, mrf_idx}, {124'd0, v.rd});
      end
      cyc++;
      case (ph)
        0: ph = 1;
        1: if (rdy) begin
             if (row == DIM - 1) ph = 2;
             else begin row++; ph = v.st ? 0 : 1; end
           end
        default: seen_done = 1;
      endcase
    end
    chk("timeout", {127'd0, seen_done}, 128'd1);
    chk("cycles", 128'(cyc), 128'((v.st ? 2 : 1) * DIM + 1 + stalls));
    @(negedge CLK);
    start = 1'b0; mem_ready = 1'b0;
    #1;
    chk("post_busy", {127'd0, busy}, 128'd0);
    chk("post_done", {127'd0, done}, 128'd0);
  endtask

  initial begin
    int cyc;
    vec_t v;
    nRST = 1'b0; start = 1'b0; is_store = 1'b0; matrix_rd = '0; base_addr = '0;
    stride = '0; mem_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < DIM; j++)
        rf[i][j] = {$urandom(), $urandom(), $urandom(), $urandom()};

    vecs[0] = '{st:0, rd:4'd3, base:32'h0000_1000, stride:4'd0, stall_row:-1, stall_len:0, rnd:0, noise:0, exp_cyc:5};
    vecs[1] = '{st:1, rd:4'd7, base:32'h0000_2000, stride:4'd8, stall_row:-1, stall_len:0, rnd:0, noise:0, exp_cyc:9};
    vecs[2] = '{st:0, rd:4'd2, base:32'h0000_1000, stride:4'd0, stall_row:1, stall_len:3, rnd:0, noise:0, exp_cyc:8};
    vecs[3] = '{st:0, rd:4'd9, base:32'hFFFF_FFF0, stride:4'd0, stall_row:-1, stall_len:0, rnd:0, noise:0, exp_cyc:5};
    vecs[4] = '{st:0, rd:4'd5, base:32'h0000_4000, stride:4'd1, stall_row:-1, stall_len:0, rnd:0, noise:1, exp_cyc:5};
    vecs[5] = '{st:1, rd:4'd15, base:32'h8000_0000, stride:4'd15, stall_row:2, stall_len:2, rnd:0, noise:0, exp_cyc:11};

    #3;
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd0);
    chk("rst_req", {127'd0, mem_req}, 128'd0);
    chk("rst_wen", {127'd0, mem_wen}, 128'd0);
    chk("rst_addr", {96'd0, mem_addr}, 128'd0);
    chk("rst_wdata", mem_wdata, 128'd0);
    chk("rst_mrf", {120'd0, mrf_wen, mrf_ren, mrf_idx, mrf_row}, 128'd0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i], cyc);
      chk($sformatf("vec%0d_cycles", i), 128'(cyc), 128'(vecs[i].exp_cyc));
      if (i == 0)
        for (int r = 0; r < DIM; r++) chk("dense_addr", {96'd0, acc_addr[r]}, 128'(32'h1000 + 32'(r) * 32'h10));
      if (i == 1)
        for (int r = 0; r < DIM; r++) chk("stride_addr", {96'd0, acc_addr[r]}, 128'(32'h2000 + 32'(r) * 32'h20));
      if (i == 3) begin
        chk("wrap0", {96'd0, acc_addr[0]}, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFF0);
        chk("wrap1", {96'd0, acc_addr[1]}, 128'h0);
        chk("wrap2", {96'd0, acc_addr[2]}, 128'h10);
        chk("wrap3", {96'd0, acc_addr[3]}, 128'h20);
      end
    end

    for (int k = 0; k < 20; k++) begin
      v.st = 1'($urandom_range(0, 1)); v.rd = 4'($urandom()); v.base = $urandom();
      v.stride = 4'($urandom()); v.stall_row = -1; v.stall_len = 0; v.rnd = 1'b1;
      v.noise = 1'($urandom_range(0, 1)); v.exp_cyc = -1;
      run_txn(v, cyc);
    end

    // Reset in the middle of row 2 of a store while the request is pending.
    @(negedge CLK);
    start = 1'b1; is_store = 1'b1; matrix_rd = 4'd5; base_addr = 32'h3000; stride = 4'd2;
    @(negedge CLK);
    start = 1'b0; mem_ready = 1'b1;
    repeat (4) @(negedge CLK);
    mem_ready = 1'b0;
    @(negedge CLK);
    #1;
    chk("mid_req", {127'd0, mem_req}, 128'd1);
    chk("mid_row", {126'd0, mrf_row}, 128'd2);
    #1 nRST = 1'b0;
    #1;
    chk("arst_busy", {127'd0, busy}, 128'd0);
    chk("arst_req", {127'd0, mem_req}, 128'd0);
    chk("arst_wen", {127'd0, mem_wen}, 128'd0);
    chk("arst_addr", {96'd0, mem_addr}, 128'd0);
    chk("arst_wdata", mem_wdata, 128'd0);
    chk("arst_mrf", {120'd0, mrf_wen, mrf_ren, mrf_idx, mrf_row}, 128'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      #1 chk("arst_no_done", {127'd0, done}, 128'd0);
    end
    nRST = 1'b1;
    v = vecs[0];
    v.rd = 4'd11;
    run_txn(v, cyc);
    chk("after_rst_cycles", 128'(cyc), 128'd5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
